// File: rtl/freq_counter_pkg.sv
// Shared types and default sizing for the multi-channel frequency counter.
package freq_counter_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } ctrlState_t;

   localparam int unsigned DefNumCh  = 4;
   localparam int unsigned DefCntW   = 16;
   localparam int unsigned DefGateW  = 24;

endpackage

// File: rtl/freq_channel.sv
// One sensor channel: 2-flop synchronizer, rising-edge detect, saturating counter
// with a sticky overflow flag.
module freq_channel
   import freq_counter_pkg::*;
#(
   parameter int unsigned CNT_W = DefCntW
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sensorIn,
   input  logic             clear,
   input  logic             countEn,
   output logic [CNT_W-1:0] countNext,
   output logic             flagNext
);

   logic             sync1Q, sync2Q, prevQ;
   logic [CNT_W-1:0] cntQ;
   logic             flagQ;
   logic             edgeDet, atMax, hit;

   assign edgeDet = sync2Q & ~prevQ;
   assign atMax   = &cntQ;
   assign hit     = countEn & edgeDet;

   // Combinational next value so the top can latch a window including its last-cycle edge.
   always_comb begin
      countNext = cntQ;
      flagNext  = flagQ;
      if (hit) begin
         if (atMax) begin
            flagNext = 1'b1;
         end else begin
            countNext = cntQ + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1Q <= 1'b0;
         sync2Q <= 1'b0;
         prevQ  <= 1'b0;
         cntQ   <= '0;
         flagQ  <= 1'b0;
      end else begin
         sync1Q <= sensorIn;
         sync2Q <= sync1Q;
         prevQ  <= sync2Q;
         if (clear) begin
            cntQ  <= '0;
            flagQ <= 1'b0;
         end else begin
            cntQ  <= countNext;
            flagQ <= flagNext;
         end
      end
   end

endmodule

// File: rtl/multi_freq_counter.sv
// Gated-window frequency counter: counts sensor edges per channel over gate_len
// clocks and latches all channels together at the end of each window.
module multi_freq_counter
   import freq_counter_pkg::*;
#(
   parameter int unsigned NUM_CH = DefNumCh,
   parameter int unsigned CNT_W  = DefCntW,
   parameter int unsigned GATE_W = DefGateW
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   input  logic [NUM_CH-1:0]       sensorFreq,
   input  logic [GATE_W-1:0]       gate_len,
   output logic [NUM_CH*CNT_W-1:0] freqValue,
   output logic [NUM_CH-1:0]       overflow,
   output logic                    valid,
   output logic                    busy
);

   ctrlState_t stateQ, stateD;
   logic [GATE_W-1:0] lenQ, lenD;
   logic [GATE_W-1:0] winQ, winD;
   logic [GATE_W-1:0] capLen;
   logic              lastCycle, clearCnt, countEn;

   logic [NUM_CH*CNT_W-1:0] cntNextAll;
   logic [NUM_CH-1:0]       flagNextAll;

   // A zero-length gate still runs a one-cycle window.
   assign capLen = (gate_len == '0) ? GATE_W'(1) : gate_len;
   assign busy   = (stateQ == RUN);

   always_comb begin
      stateD    = stateQ;
      lenD      = lenQ;
      winD      = winQ;
      lastCycle = 1'b0;
      clearCnt  = 1'b0;
      countEn   = 1'b0;
      unique case (stateQ)
         IDLE: begin
            clearCnt = 1'b1;
            winD     = '0;
            if (enable) begin
               stateD = RUN;
               lenD   = capLen;
            end
         end
         RUN: begin
            if (!enable) begin
               stateD   = IDLE;
               clearCnt = 1'b1;
               winD     = '0;
            end else begin
               countEn = 1'b1;
               if (winQ == lenQ - GATE_W'(1)) begin
                  // Last cycle: latch, then restart the next window immediately.
                  lastCycle = 1'b1;
                  clearCnt  = 1'b1;
                  winD      = '0;
                  lenD      = capLen;
               end else begin
                  winD = winQ + GATE_W'(1);
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateQ    <= IDLE;
         lenQ      <= '0;
         winQ      <= '0;
         freqValue <= '0;
         overflow  <= '0;
         valid     <= 1'b0;
      end else begin
         stateQ <= stateD;
         lenQ   <= lenD;
         winQ   <= winD;
         valid  <= lastCycle;
         if (lastCycle) begin
            freqValue <= cntNextAll;
            overflow  <= flagNextAll;
         end
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : gCh
      freq_channel #(
         .CNT_W (CNT_W)
      ) uCh (
         .clk       (clk),
         .rst_n     (rst_n),
         .sensorIn  (sensorFreq[i]),
         .clear     (clearCnt),
         .countEn   (countEn),
         .countNext (cntNextAll[i*CNT_W +: CNT_W]),
         .flagNext  (flagNextAll[i])
      );
   end

endmodule

// File: tb/tb_multi_freq_counter.sv
// Scoreboard bench: stimulus queues expected windows, monitors pop on valid.
module tb_multi_freq_counter;

   typedef struct packed {
      logic [3:0][15:0] lo;
      logic [3:0][15:0] hi;
      logic [3:0]       ovf;
      logic [15:0]      gap;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic [3:0]  sensor;
   logic [23:0] gateLen;
   logic [63:0] freqValue;
   logic [3:0]  overflow;
   logic        valid, busy;

   logic        en2;
   logic [0:0]  sens2;
   logic [7:0]  gate2;
   logic [3:0]  fv2;
   logic [0:0]  ov2;
   logic        valid2, busy2;

   int   per[4];
   int   per2;
   int   cyc = 0;
   int   last1 = 0, last2 = 0;
   int   nChecks = 0, nFail = 0;
   int   k;
   exp_t q1[$];
   exp_t q2[$];
   exp_t e1, e2;

   multi_freq_counter #(.NUM_CH(4), .CNT_W(16), .GATE_W(24)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .sensorFreq (sensor),
      .gate_len   (gateLen),
      .freqValue  (freqValue),
      .overflow   (overflow),
      .valid      (valid),
      .busy       (busy)
   );

   multi_freq_counter #(.NUM_CH(1), .CNT_W(4), .GATE_W(8)) dut2 (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (en2),
      .sensorFreq (sens2),
      .gate_len   (gate2),
      .freqValue  (fv2),
      .overflow   (ov2),
      .valid      (valid2),
      .busy       (busy2)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Square waves derived from the free-running cycle count, updated just after each edge.
   initial begin
      sensor = '0;
      sens2  = '0;
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < 4; i++)
            sensor[i] = (per[i] != 0) && ((cyc % per[i]) < per[i] / 2);
         sens2[0] = (per2 != 0) && ((cyc % per2) < per2 / 2);
      end
   end

   task automatic checkRange(input string name, input int act, input int lo, input int hi);
      nChecks++;
      if (act < lo || act > hi) begin
         nFail++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   function automatic exp_t mkExp(input int l0, input int h0, input int l1, input int h1,
                                  input int l2, input int h2, input int l3, input int h3,
                                  input int gap, input logic [3:0] ovf);
      exp_t e;
      e.lo[0] = 16'(l0); e.hi[0] = 16'(h0);
      e.lo[1] = 16'(l1); e.hi[1] = 16'(h1);
      e.lo[2] = 16'(l2); e.hi[2] = 16'(h2);
      e.lo[3] = 16'(l3); e.hi[3] = 16'(h3);
      e.ovf   = ovf;
      e.gap   = 16'(gap);
      return e;
   endfunction

   task automatic waitValid(input bit which, input int limit, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(which ? valid2 : valid) && n < limit);
      if (!(which ? valid2 : valid)) checkRange("valid_timeout", 0, 1, 1);
   endtask

   always @(negedge clk) begin
      if (rst_n && valid) begin
         if (q1.size() == 0) begin
            checkRange("unexpected_valid", 1, 0, 0);
         end else begin
            e1 = q1.pop_front();
            for (int i = 0; i < 4; i++)
               checkRange($sformatf("ch%0d_count", i), int'(freqValue[i*16 +: 16]),
                          int'(e1.lo[i]), int'(e1.hi[i]));
            checkRange("overflow", int'(overflow), int'(e1.ovf), int'(e1.ovf));
            if (e1.gap != 0) checkRange("window_gap", cyc - last1, int'(e1.gap), int'(e1.gap));
         end
         last1 = cyc;
      end
   end

   always @(negedge clk) begin
      if (rst_n && valid2) begin
         if (q2.size() == 0) begin
            checkRange("unexpected_valid2", 1, 0, 0);
         end else begin
            e2 = q2.pop_front();
            checkRange("sat_count", int'(fv2), int'(e2.lo[0]), int'(e2.hi[0]));
            checkRange("sat_overflow", int'(ov2), int'(e2.ovf[0]), int'(e2.ovf[0]));
            if (e2.gap != 0) checkRange("window_gap2", cyc - last2, int'(e2.gap), int'(e2.gap));
         end
         last2 = cyc;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      per     = '{10, 8, 16, 32};
      per2    = 2;
      gateLen = 24'd100;
      gate2   = 8'd64;
      enable  = 1'b0;
      en2     = 1'b0;
      rst_n   = 1'b0;
      repeat (3) @(negedge clk);
      checkRange("rst_valid", int'(valid), 0, 0);
      checkRange("rst_busy", int'(busy), 0, 0);
      checkRange("rst_freq", int'(freqValue != 0), 0, 0);
      checkRange("rst_ovf", int'(overflow), 0, 0);
      checkRange("rst_busy2", int'(busy2), 0, 0);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);

      // gate 100, ch0 period 10
      q1.push_back(mkExp(9, 11, 11, 14, 5, 8, 2, 5, 0, 4'h0));
      q1.push_back(mkExp(9, 11, 11, 14, 5, 8, 2, 5, 100, 4'h0));
      q1.push_back(mkExp(9, 11, 11, 14, 5, 8, 2, 5, 100, 4'h0));
      enable = 1'b1;
      // Enable sampled at the next edge; first window then spans gate_len RUN cycles.
      waitValid(0, 300, k);
      checkRange("first_valid_latency", k, 101, 101);
      checkRange("busy_in_run", int'(busy), 1, 1);
      waitValid(0, 300, k);
      waitValid(0, 300, k);
      enable = 1'b0;
      @(negedge clk);
      checkRange("busy_after_stop", int'(busy), 0, 0);

      // periods 4/8/16/32, gate 256
      per[0] = 4;
      repeat (10) @(negedge clk);
      gateLen = 24'd256;
      q1.push_back(mkExp(63, 65, 31, 33, 15, 17, 7, 9, 0, 4'h0));
      q1.push_back(mkExp(63, 65, 31, 33, 15, 17, 7, 9, 256, 4'h0));
      enable = 1'b1;
      waitValid(0, 400, k);
      waitValid(0, 400, k);
      enable = 1'b0;
      repeat (5) @(negedge clk);

      // abort at cycle 50 of a 100-cycle window
      gateLen = 24'd100;
      enable  = 1'b1;
      repeat (50) @(negedge clk);
      checkRange("busy_mid_window", int'(busy), 1, 1);
      enable = 1'b0;
      @(negedge clk);
      checkRange("busy_after_abort", int'(busy), 0, 0);
      repeat (150) @(negedge clk);
      checkRange("held_ch0", int'(freqValue[15:0]), 63, 65);
      checkRange("held_ch1", int'(freqValue[31:16]), 31, 33);
      checkRange("held_ch3", int'(freqValue[63:48]), 7, 9);

      // gate 0 behaves as a one-cycle window
      gateLen = 24'd0;
      q1.push_back(mkExp(0, 1, 0, 1, 0, 1, 0, 1, 0, 4'h0));
      for (int i = 0; i < 4; i++) q1.push_back(mkExp(0, 1, 0, 1, 0, 1, 0, 1, 1, 4'h0));
      enable = 1'b1;
      waitValid(0, 10, k);
      checkRange("gate0_latency", k, 2, 2);
      repeat (4) waitValid(0, 10, k);
      enable = 1'b0;
      repeat (10) @(negedge clk);

      // gate_len changed mid-window takes effect only on the next window
      gateLen = 24'd100;
      q1.push_back(mkExp(24, 26, 11, 14, 5, 8, 2, 5, 0, 4'h0));
      q1.push_back(mkExp(4, 6, 1, 4, 0, 3, 0, 2, 20, 4'h0));
      enable = 1'b1;
      repeat (30) @(negedge clk);
      gateLen = 24'd20;
      waitValid(0, 200, k);
      checkRange("len_change_window1", k + 30, 101, 101);
      waitValid(0, 100, k);
      checkRange("len_change_window2", k, 20, 20);
      enable = 1'b0;
      repeat (5) @(negedge clk);

      // asynchronous reset mid-window
      gateLen = 24'd100;
      enable  = 1'b1;
      repeat (40) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkRange("async_rst_busy", int'(busy), 0, 0);
      checkRange("async_rst_freq", int'(freqValue != 0), 0, 0);
      checkRange("async_rst_ovf", int'(overflow), 0, 0);
      checkRange("async_rst_valid", int'(valid), 0, 0);
      repeat (3) @(negedge clk);
      q1.push_back(mkExp(24, 26, 11, 14, 5, 8, 2, 5, 0, 4'h0));
      rst_n = 1'b1;
      waitValid(0, 200, k);
      checkRange("post_reset_latency", k, 101, 101);
      enable = 1'b0;
      repeat (5) @(negedge clk);

      // 4-bit counter: saturate at period 2, then recover at period 10
      q2.push_back(mkExp(15, 15, 0, 0, 0, 0, 0, 0, 0, 4'h1));
      q2.push_back(mkExp(6, 7, 0, 0, 0, 0, 0, 0, 64, 4'h0));
      q2.push_back(mkExp(6, 7, 0, 0, 0, 0, 0, 0, 64, 4'h0));
      en2 = 1'b1;
      repeat (40) @(negedge clk);
      per2 = 10;
      waitValid(1, 100, k);
      checkRange("sat_window_latency", k + 40, 65, 65);
      waitValid(1, 100, k);
      waitValid(1, 100, k);
      en2 = 1'b0;

      repeat (20) @(negedge clk);
      checkRange("q1_drained", q1.size(), 0, 0);
      checkRange("q2_drained", q2.size(), 0, 0);
      $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
      $finish;
   end

endmodule

// File: doc/multi_freq_counter.md
MULTI_FREQ_COUNTER -- requirements
Module: multi_freq_counter

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent sensor channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 16, width of each per-channel edge count.
REQ-003 SHALL have parameter GATE_W, default 24, width of the gate-window length.
REQ-004 SHALL have port clk  input  1  single system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port enable  input  1  high runs gate windows; low idles the block.
REQ-007 SHALL have port sensorFreq  input  NUM_CH  asynchronous sensor square waves, bit i = channel i.
REQ-008 SHALL have port gate_len  input  GATE_W  window length in clk cycles.
REQ-009 SHALL have port freqValue  output  NUM_CH*CNT_W  latched counts, channel i at bits [i*CNT_W +: CNT_W].
REQ-010 SHALL have port overflow  output  NUM_CH  per-channel saturation flag for the latched window.
REQ-011 SHALL have port valid  output  1  one-cycle pulse when freqValue/overflow update.
REQ-012 SHALL have port busy  output  1  high while a window is running.

Function
REQ-013 Each sensorFreq bit SHALL pass through a 2-flop synchronizer and then a rising-edge detector; a detected edge counts in the cycle after the third register stage (3-cycle input latency).
REQ-014 Control FSM SHALL have states IDLE and RUN.
REQ-015 IDLE -> RUN on the first cycle enable=1; gate_len is captured into an internal register on that transition, and 0 is treated as 1.
REQ-016 In RUN, a window counter SHALL count 0..len-1; on the cycle it equals len-1 (the last cycle), every channel count, including any edge detected that cycle, SHALL be latched into freqValue, its saturation flag into overflow, and valid SHALL pulse high for exactly that cycle's output update (valid high the following cycle, one cycle wide).
REQ-017 Windows SHALL run back-to-back with no dead cycle: the cycle after a window's last cycle begins the next window, the counts restart from 0, and gate_len is re-captured.
REQ-018 Each channel count SHALL saturate at 2^CNT_W-1; any edge arriving at saturation SHALL set that channel's sticky flag, which is cleared at the window start.
REQ-019 Dropping enable in RUN SHALL abort the window: return to IDLE next cycle, clear the counts and window counter, issue no valid, and leave freqValue/overflow holding their prior values.
REQ-020 Changes to gate_len in mid-window SHALL have no effect until the next window capture.
REQ-021 busy SHALL equal (state == RUN).
REQ-022 Edges in IDLE SHALL NOT be counted; the synchronizers keep running so that no stale edge fires on entry.

Reset
REQ-023 rst_n low SHALL asynchronously force state=IDLE, with freqValue=0, overflow=0, valid=0, busy=0, all counters, synchronizers and the captured length cleared.
REQ-024 Reset asserted mid-window SHALL discard the window; after release the block behaves as if freshly started.

Structure
REQ-025 A package freq_counter_pkg SHALL hold the FSM state typedef (IDLE, RUN) and the default parameter constants.
REQ-026 A sub-module freq_channel (synchronizer, edge detect, saturating counter, sticky flag; inputs clear/enable) SHALL be instantiated NUM_CH times by generate.

Verification
REQ-027 gate_len=100, ch0 toggling with period 10 clk, enable held -> each valid reports ch0=10 (±1 for phase), overflow[0]=0.
REQ-028 NUM_CH=4, distinct periods 4/8/16/32 clk, gate_len=256 -> counts 64/32/16/8 (±1), all channels latched on the same valid.
REQ-029 CNT_W=4, ch0 period 2 clk, gate_len=64 -> freqValue ch0=15, overflow[0]=1; next window at period 10 -> 6 or 7, overflow[0]=0.
REQ-030 enable low at cycle 50 of a 100-cycle window -> no valid, freqValue unchanged, busy=0 the next cycle.
REQ-031 gate_len=0 -> window of 1 cycle, valid every cycle; gate_len changed mid-window from 100 to 20 -> current window still spans 100 cycles.
REQ-032 rst_n pulsed low mid-window -> all outputs 0 immediately (asynchronous); the first valid after release occurs gate_len cycles after restart.
